// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, queue entry type and helpers for the writeback arbiter
//
// Contents:
//   WB_DATA_W, WB_ADDR_W, WB_NREG  default register data/address widths and register count
//   wb_entry_t                     queued load entry {live, rd, data}
//   onehot_rd(rd)                  one-hot register select used to build pending masks
package wb_pkg;

  localparam int WB_DATA_W = 19;
  localparam int WB_ADDR_W = 4;
  localparam int WB_NREG   = 2 ** WB_ADDR_W;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [WB_NREG-1:0] onehot_rd(input logic [WB_ADDR_W-1:0] rd);
    logic [WB_NREG-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - in-order load result queue with kill-by-register and pending mask
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push/push_entry enqueue one entry at the tail (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   kill_en/kill_rd clear the live bit of every stored entry targeting kill_rd
//   head_entry      entry at the head of the queue
//   empty, full     occupancy flags from the registered count
//   count           number of occupied entries
//   pending_mask    OR of one-hot(rd) over live entries
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   kill_en,
  input  logic [WB_ADDR_W-1:0]   kill_rd,
  output wb_entry_t              head_entry,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [WB_NREG-1:0]     pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [DEPTH-1:0]     live_q;
  logic [WB_ADDR_W-1:0] rd_q   [DEPTH];
  logic [WB_DATA_W-1:0] data_q [DEPTH];
  logic                 push_ok;
  logic                 pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Live bits of free slots are kept at 0, so the pending mask and kill logic
  // can scan every slot without consulting the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == kill_rd) live_q[i] <= 1'b0;
        end
      end
      if (pop_ok) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // The push slot never equals a pop or kill target that still matters:
      // push carries its own live bit already resolved against the same-cycle kill.
      if (push_ok) begin
        live_q[wr_ptr] <= push_entry.live;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_q[wr_ptr]   <= push_entry.rd;
      data_q[wr_ptr] <= push_entry.data;
    end
  end

  always_comb begin
    head_entry.live = live_q[rd_ptr];
    head_entry.rd   = rd_q[rd_ptr];
    head_entry.data = data_q[rd_ptr];
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask = pending_mask | onehot_rd(rd_q[i]);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and load results onto the register file write port
//
// Optional feature: define WB_BYPASS_EN to let a load that finds the queue empty
// and no ALU write present go straight to the write port with 1-cycle latency.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data     single-cycle ALU result (has write-port priority)
//   mem_valid/mem_rd/mem_data     load result offer, accepted when mem_ready is high
//   mem_ready                     load queue not full
//   we3/a3/wd3                    registered register file write port
//   pending_mask                  registers targeted by live queued loads
//   q_count                       occupied load queue entries
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   we3,
  output logic [ADDR_W-1:0]      a3,
  output logic [DATA_W-1:0]      wd3,
  output logic [2**ADDR_W-1:0]   pending_mask,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic               alu_write;
  logic               load_keep;
  logic               same_rd;
  logic               bypass;
  logic               q_push;
  logic               q_pop;
  logic               q_empty;
  logic               q_full;
  wb_entry_t          push_entry;
  wb_entry_t          head_entry;
  logic [WB_NREG-1:0] q_mask;

  // Writes to register 0 are discarded; a load to r0 still handshakes.
  assign alu_write = alu_valid && (alu_rd != '0);
  assign load_keep = mem_valid && mem_ready && (mem_rd != '0);
  // A load arriving with an ALU write to the same register is the older value.
  assign same_rd   = alu_write && (mem_rd == alu_rd);

`ifdef WB_BYPASS_EN
  assign bypass = load_keep && q_empty && !alu_write;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = load_keep && !bypass;
  assign q_pop  = !alu_write && !q_empty;

  always_comb begin
    push_entry.live = !same_rd;
    push_entry.rd   = WB_ADDR_W'(mem_rd);
    push_entry.data = WB_DATA_W'(mem_data);
  end

  wb_load_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (q_push),
    .push_entry  (push_entry),
    .pop         (q_pop),
    .kill_en     (alu_write),
    .kill_rd     (WB_ADDR_W'(alu_rd)),
    .head_entry  (head_entry),
    .empty       (q_empty),
    .full        (q_full),
    .count       (q_count),
    .pending_mask(q_mask)
  );

  assign mem_ready    = !q_full;
  assign pending_mask = NREG'(q_mask);

  // a3/wd3 keep their last values on idle cycles and on killed-head pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (alu_write) begin
      we3 <= 1'b1;
      a3  <= alu_rd;
      wd3 <= alu_data;
    end else if (q_pop) begin
      we3 <= head_entry.live;
      if (head_entry.live) begin
        a3  <= ADDR_W'(head_entry.rd);
        wd3 <= DATA_W'(head_entry.data);
      end
    end else if (bypass) begin
      we3 <= 1'b1;
      a3  <= mem_rd;
      wd3 <= mem_data;
    end else begin
      we3 <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; drives its single write port (WE3/A3/WD3).
- Merges two result sources: single-cycle ALU results and variable-latency load results from the memory interface.
- ALU has priority on the write port; loads wait in a small in-order queue.
- Resolves write-after-write conflicts between queued loads and younger ALU writes, and exports a pending-register mask for the hazard logic.

Parameters:
- DATA_W, 19, register data width.
- ADDR_W, 4, register address width (16 registers).
- DEPTH, 4, load queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  queue can accept a load (not full)
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- we3  out  1  register file write enable
- a3  out  ADDR_W  register file write address
- wd3  out  DATA_W  register file write data
- pending_mask  out  2**ADDR_W  bit r set means a live queued load targets register r
- q_count  out  clog2(DEPTH)+1  occupied queue entries

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - Reset clears we3, a3, wd3, the queue pointers, q_count and all entry valid bits.
  - pending_mask resets to 0 and mem_ready to 1.
  - Reset asserted mid-operation discards all queued loads; no write is issued.
- Load acceptance:
  - A load is accepted when mem_valid and mem_ready are both high.
  - mem_ready is the negation of full, computed from the registered count. It does not rise in the same cycle as a pop.
- Register 0 writes: any ALU or load result with rd equal to 0 is dropped. A dropped load is still accepted (handshake completes) but is not enqueued, and produces no write.
- Write-port arbitration (outputs registered, 1-cycle latency):
  - If alu_valid and alu_rd != 0: next cycle we3=1, a3=alu_rd, wd3=alu_data.
  - Otherwise, if the queue is non-empty: pop the head. If the head is live, next cycle we3=1 with its rd/data. If the head was killed, we3=0 and the pop still happens.
  - Otherwise: we3=0. a3 and wd3 hold their last values.
- WAW kill:
  - An ALU write to register r clears the live bit of every queued entry with rd == r.
  - A load accepted in the same cycle with mem_rd == alu_rd is treated as older. It is enqueued already killed, or, in the bypass path, dropped.
- Simultaneous push and pop: allowed; q_count stays unchanged.
- Queue order: entries drain strictly in acceptance order.
- pending_mask: OR of one-hot(rd) over live entries. It is combinational from queue state and reflects kills starting the cycle after the ALU write.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a load accepted when the queue is empty and no ALU write is present goes straight to the output registers (1-cycle latency) and is not enqueued.
- Undefined: every accepted load is enqueued; minimum load-to-we3 latency is 2 cycles. Everything else is identical.

Decomposition:
- Package wb_pkg holds:
  - constants WB_DATA_W=19 and WB_ADDR_W=4;
  - typedef wb_entry_t {live, rd, data};
  - a function onehot_rd(rd).
- One sub-module, wb_load_queue: circular storage, pointers, count, kill-by-rd port, pending_mask generation.
- wb_arbiter holds the arbitration logic and the output registers.

Test Plan:
- Reset check: assert rst mid-stream with 3 entries queued -> we3=0, q_count=0, pending_mask=0, mem_ready=1 immediately (asynchronous); no write after release.
- Basic writes:
  - ALU-only: alu_rd=5, alu_data=19'h1ABCD -> next cycle we3=1, a3=5, wd3=19'h1ABCD.
  - alu_rd=0 -> we3 stays 0.
- Priority and full queue: alu_valid held for 6 cycles while loads arrive for rd=1..4 -> queue fills (q_count=4, mem_ready=0, pending_mask=16'h001E). When ALU idles, writes appear for rd 1,2,3,4 in order on consecutive cycles.
- WAW kill: queue a load rd=7 data 19'h00111, then an ALU write rd=7 data 19'h00222 -> pending_mask bit 7 clears; only 19'h00222 is written to r7; the popped killed entry gives a cycle with we3=0.
- Same-cycle conflict: alu_valid and mem_valid both with rd=9 -> only the ALU data is written to r9, and q_count does not retain a live entry.
- Bypass on/off: idle queue, single load rd=3 -> we3 one cycle after acceptance with WB_BYPASS_EN, two cycles without.
